// File: rtl/cskip_sub_seq_16b_if.sv
`default_nettype none
// ============================================================================
//  Module      : cskip_sub_seq_16b_if
//  Description : Operand/result handshake bundle for the sequential subtractor.
//  Revision    : 1.0
// ============================================================================
interface cskip_sub_seq_16b_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, ovf
  );
endinterface
`default_nettype wire

// File: rtl/cskip_sub_seq_16b.sv
`default_nettype none
// ============================================================================
//  Module      : cskip_sub_seq_16b
//  Description : Multi-cycle a - b subtractor, one carry-skip slice per clock.
//  Revision    : 1.0
// ============================================================================
module cskip_sub_seq_16b #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic                clk,
  input  logic                rst,
  cskip_sub_seq_16b_if.slave  bus
);

  localparam int NBLK = WIDTH / BLK;
  localparam int IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int AW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  nb_q;
  logic              carry_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  diff_q;
  logic              borrow_q;
  logic              ovf_q;
  logic              in_ready_q;
  logic              out_valid_q;

  logic [AW-1:0]     w_base;
  logic [BLK-1:0]    w_a_s;
  logic [BLK-1:0]    w_nb_s;
  logic [BLK-1:0]    w_sum;
  logic              w_rca_cout;
  logic              w_prop;
  logic              carry_d;
  logic [WIDTH-1:0]  diff_d;
  logic              w_last;
  logic              ovf_d;

  assign w_base = AW'(idx_q) * AW'(BLK);
  assign w_a_s  = a_q[w_base +: BLK];
  assign w_nb_s = nb_q[w_base +: BLK];
  assign w_last = (idx_q == IDXW'(NBLK - 1));

  // Ripple through the current slice; the skip mux bypasses it when every bit propagates.
  always_comb begin : p_slice
    logic c;
    c     = carry_q;
    w_sum = '0;
    for (int i = 0; i < BLK; i++) begin
      w_sum[i] = w_a_s[i] ^ w_nb_s[i] ^ c;
      c        = (w_a_s[i] & w_nb_s[i]) | (c & (w_a_s[i] ^ w_nb_s[i]));
    end
    w_rca_cout = c;
  end

  assign w_prop  = &(w_a_s ^ w_nb_s);
  assign carry_d = w_prop ? carry_q : w_rca_cout;

  always_comb begin
    diff_d                  = diff_q;
    diff_d[w_base +: BLK]   = w_sum;
  end

  // nb_q holds ~b, so the subtrahend sign is its inverted MSB.
  assign ovf_d = (a_q[WIDTH-1] != ~nb_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      nb_q        <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            nb_q       <= ~bus.b;
            carry_q    <= 1'b1;
            idx_q      <= '0;
            diff_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_CALC;
          end
        end
        S_CALC: begin
          diff_q  <= diff_d;
          carry_q <= carry_d;
          idx_q   <= idx_q + IDXW'(1);
          if (w_last) begin
            borrow_q    <= ~carry_d;
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cskip_sub_seq_16b.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cskip_sub_seq_16b
//  Description : Directed plus random checks of the sequential subtractor.
//  Revision    : 1.0
// ============================================================================
module tb_cskip_sub_seq_16b;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  cskip_sub_seq_16b_if #(.WIDTH(16)) bus ();

  cskip_sub_seq_16b #(.WIDTH(16), .BLK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic ref_model(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] d, output logic bo, output logic ov);
    int sa, sb, sd;
    d  = 16'(int'(a) - int'(b));
    bo = (int'(a) < int'(b));
    sa = int'($signed(a));
    sb = int'($signed(b));
    sd = sa - sb;
    ov = (sd > 32767) || (sd < -32768);
  endtask

  // Starts and ends at a falling edge with the block idle.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int stall);
    logic [15:0] ed;
    logic        eb, eo;
    ref_model(a, b, ed, eb, eo);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 16'($urandom);
    bus.b        = 16'($urandom);
    chk("calc_in_ready", 32'(bus.in_ready), 32'd0);
    chk("calc_diff_clr", 32'(bus.diff), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("calc_out_valid", 32'(bus.out_valid), 32'd0);
    end
    @(negedge clk);
    chk("done_out_valid", 32'(bus.out_valid), 32'd1);
    chk("diff", 32'(bus.diff), 32'(ed));
    chk("borrow", 32'(bus.borrow), 32'(eb));
    chk("ovf", 32'(bus.ovf), 32'(eo));
    for (int k = 0; k < stall; k++) begin
      bus.in_valid = 1'b1;
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
      @(negedge clk);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_diff", 32'({bus.diff, bus.borrow, bus.ovf}), 32'({ed, eb, eo}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("post_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_outputs", 32'({bus.diff, bus.borrow, bus.ovf}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(16'h1234, 16'h0234, 0);
    do_op(16'h0000, 16'h0001, 0);
    do_op(16'h8000, 16'h0001, 0);
    do_op(16'hA5A5, 16'hA5A5, 0);
    do_op(16'h7FFF, 16'hFFFF, 2);
    do_op(16'hFFFF, 16'h0000, 0);
    do_op(16'h1357, 16'h2468, 10);

    // Abort during the second calculation cycle.
    bus.in_valid = 1'b1;
    bus.a        = 16'h4321;
    bus.b        = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_stays_idle", 32'({bus.out_valid, bus.in_ready}), 32'b01);
    end
    do_op(16'h4321, 16'h1111, 0);

    for (int n = 0; n < 40; n++) begin
      do_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
